// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock byte FIFO placed between a producer and a consumer that share
//   one clock domain. Write and read strobes are active-low. Read data is
//   registered and appears on data_out right after the edge that accepts the
//   read.
//
// Ports
//   clock     : system clock, all state changes on the rising edge
//   reset     : synchronous, active-high reset
//   data_in   : write data, captured when a write is accepted
//   write_n   : active-low write request
//   read_n    : active-low read request
//   data_out  : registered read data, changes only on an accepted read
//   empty     : high when no entries are stored
//   full      : high when DEPTH entries are stored
//   count     : current occupancy, 0..DEPTH
//   overflow  : one-cycle pulse when a write is rejected
//   underflow : one-cycle pulse when a read is rejected
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write_n,
  input  logic              read_n,
  output logic [DATA_W-1:0] data_out,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W-1:0] c_ptr_one    = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   c_cnt_one    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   c_cnt_zero   = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   c_cnt_full   = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_data_out;
  logic              r_empty;
  logic              r_full;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_wr_req;
  logic              w_rd_req;
  logic              w_wr_ok;
  logic              w_rd_ok;
  logic              w_ovf_nxt;
  logic              w_udf_nxt;
  logic [ADDR_W:0]   w_count_nxt;

  // Request decode, acceptance rules and next occupancy.
  always_comb begin
    w_wr_req    = ~write_n;
    w_rd_req    = ~read_n;
    w_wr_ok     = 1'b0;
    w_rd_ok     = 1'b0;
    w_ovf_nxt   = 1'b0;
    w_udf_nxt   = 1'b0;
    w_count_nxt = r_count;

    // A read is only ever refused when empty; no bypass from a same-cycle write.
    if (w_rd_req && !r_empty) begin
      w_rd_ok = 1'b1;
    end else begin
      w_udf_nxt = w_rd_req;
    end

    // At full, a write is still accepted when a read frees the slot this edge.
    if (w_wr_req && (!r_full || w_rd_req)) begin
      w_wr_ok = 1'b1;
    end else begin
      w_ovf_nxt = w_wr_req;
    end

    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_nxt = r_count + c_cnt_one;
      2'b01:   w_count_nxt = r_count - c_cnt_one;
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers, occupancy, registered flags and read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr      <= {ADDR_W{1'b0}};
      r_rptr      <= {ADDR_W{1'b0}};
      r_count     <= c_cnt_zero;
      r_data_out  <= {DATA_W{1'b0}};
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wptr <= r_wptr + c_ptr_one;
      end
      if (w_rd_ok) begin
        r_rptr     <= r_rptr + c_ptr_one;
        r_data_out <= r_mem[r_rptr];
      end
      r_count     <= w_count_nxt;
      r_empty     <= (w_count_nxt == c_cnt_zero);
      r_full      <= (w_count_nxt == c_cnt_full);
      r_overflow  <= w_ovf_nxt;
      r_underflow <= w_udf_nxt;
    end
  end

  // Storage array; contents are not reset. At full with a simultaneous read,
  // wptr equals rptr and the read above samples the old word before it is
  // overwritten.
  always_ff @(posedge clock) begin
    if (w_wr_ok && !reset) begin
      r_mem[r_wptr] <= data_in;
    end
  end

  assign data_out  = r_data_out;
  assign empty     = r_empty;
  assign full      = r_full;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// Testbench for sync_fifo: directed scenarios followed by random traffic.
// A queue-based reference model predicts the state after every edge; the
// prediction is pushed into a scoreboard and a separate monitor compares it
// with the DUT outputs one time unit after each rising edge.
module tb_sync_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clock;
  logic              reset;
  logic [DATA_W-1:0] data_in;
  logic              write_n;
  logic              read_n;
  logic [DATA_W-1:0] data_out;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .data_in   (data_in),
    .write_n   (write_n),
    .read_n    (read_n),
    .data_out  (data_out),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  typedef struct {
    int dout;
    int cnt;
    int emp;
    int ful;
    int ovf;
    int udf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  // reference model state
  byte unsigned model_q[$];
  int           model_dout = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle at the falling edge, update the model, push the prediction.
  task automatic cycle(input bit rst, input bit wr, input bit rd, input int din);
    exp_t e;
    int   len;
    bit   ovf;
    bit   udf;
    @(negedge clock);
    reset   = rst;
    write_n = ~wr;
    read_n  = ~rd;
    data_in = din[7:0];
    ovf = 1'b0;
    udf = 1'b0;
    if (rst) begin
      model_q.delete();
      model_dout = 0;
    end else begin
      len = model_q.size();
      if (rd && len == 0) udf = 1'b1;
      if (wr && len == DEPTH && !rd) ovf = 1'b1;
      if (rd && len > 0) model_dout = int'(model_q.pop_front());
      if (wr && !ovf) model_q.push_back(din[7:0]);
    end
    e.dout = model_dout;
    e.cnt  = model_q.size();
    e.emp  = (model_q.size() == 0) ? 1 : 0;
    e.ful  = (model_q.size() == DEPTH) ? 1 : 0;
    e.ovf  = ovf ? 1 : 0;
    e.udf  = udf ? 1 : 0;
    exp_q.push_back(e);
  endtask

  // Monitor: compare each prediction with the DUT just after its edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("data_out",  int'(data_out),  e.dout);
        check("count",     int'(count),     e.cnt);
        check("empty",     int'(empty),     e.emp);
        check("full",      int'(full),      e.ful);
        check("overflow",  int'(overflow),  e.ovf);
        check("underflow", int'(underflow), e.udf);
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: stimulus_done=%0d expected 1", stim_done);
    $fatal(1, "timeout");
  end

  initial begin
    reset   = 1'b1;
    write_n = 1'b1;
    read_n  = 1'b1;
    data_in = 8'h00;

    // reset
    cycle(1'b1, 1'b0, 1'b0, 0);
    // reset overrides a simultaneous request
    cycle(1'b1, 1'b1, 1'b1, 8'h55);

    // fill 0x00..0x0F, then overflow with 0xAA
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, i);
    cycle(1'b0, 1'b1, 1'b0, 8'hAA);
    // drain in order, then underflow with data_out holding
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 1'b1, 0);
    cycle(1'b0, 1'b0, 1'b1, 0);
    cycle(1'b0, 1'b0, 1'b0, 0);

    // count=5, simultaneous read/write
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 8'h20 + i);
    cycle(1'b0, 1'b1, 1'b1, 8'h30);
    // top up to full, simultaneous read/write at full
    for (int i = 0; i < DEPTH - 5; i++) cycle(1'b0, 1'b1, 1'b0, 8'h40 + i);
    cycle(1'b0, 1'b1, 1'b1, 8'h5A);
    cycle(1'b0, 1'b1, 1'b0, 8'hAB);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 1'b1, 0);

    // simultaneous read/write at empty
    cycle(1'b0, 1'b1, 1'b1, 8'h77);
    cycle(1'b0, 1'b0, 1'b1, 0);

    // wrap-around: 3 preloaded, 24 interleaved pairs
    cycle(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'h80 + i);
    for (int i = 0; i < 24; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'h90 + i);
      cycle(1'b0, 1'b0, 1'b1, 0);
    end

    // reset mid-stream with 7 stored, then read underflows
    cycle(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 1'b0, 8'hC0 + i);
    cycle(1'b1, 1'b0, 1'b0, 0);
    cycle(1'b0, 1'b0, 1'b1, 0);

    // random traffic with varying write/read bias
    for (int i = 0; i < 600; i++) begin
      int wbias;
      wbias = (i < 200) ? 70 : ((i < 400) ? 30 : 50);
      cycle(($urandom_range(0, 99) < 1),
            ($urandom_range(0, 99) < wbias),
            ($urandom_range(0, 99) < 100 - wbias),
            int'($urandom_range(0, 255)));
    end

    // idle until the monitor has consumed every prediction (bounded)
    cycle(1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clock);
    #2;
    check("scoreboard_left", exp_q.size(), 0);
    stim_done = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
